pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload through STAGES register slots.
- Adds features the fixed registers lack:
  - valid/ready handshake, so a stage stalls when the next stage is not ready;
  - synchronous flush that inserts bubbles;
  - occupancy reporting.
- Sits between any two processor stages, for example EX to MEM with CTRL_W=7 and DATA_W=51.

Parameters:
- CTRL_W, 8: control bits (regwrite, memwrite, halt, ...); forced to 0 in every empty or flushed slot.
- DATA_W, 48: payload bits (ALU result, PC+2, read data, write register); never cleared except by reset.
- STAGES, 1: number of register slots in series; legal range is 1..4.
- CNT_W, 3: width of the occupancy output; must be at least clog2(STAGES+1).

Ports:
- clk in 1: clock; all state updates on the rising edge.
- rst in 1: synchronous, active-high reset.
- flush in 1: drop every slot's contents and any beat offered this cycle.
- in_valid in 1: upstream offers a beat.
- in_ready out 1: the slot chain can accept a beat this cycle.
- in_ctrl in CTRL_W: control field of the incoming beat.
- in_data in DATA_W: payload of the incoming beat.
- out_valid out 1: the last slot holds a valid beat.
- out_ready in 1: downstream accepts the beat this cycle.
- out_ctrl out CTRL_W: control field of the last slot.
- out_data out DATA_W: payload of the last slot.
- occupancy out CNT_W: number of valid slots, 0..STAGES.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); it is sampled on the rising edge of clk.
- Reset: every slot has valid=0, ctrl=0, data=0. Consequently out_valid=0, out_ctrl=0, out_data=0 and occupancy=0. in_ready=1 in the first cycle after reset, provided flush=0. rst takes priority over flush and over any transfer in the same cycle.
- Slot numbering: slot 0 receives input; slot STAGES-1 drives the outputs.
- Advance rule:
  - adv[STAGES-1] = out_ready | ~valid[STAGES-1]
  - adv[i] = adv[i+1] | ~valid[i]
  - in_ready = adv[0] & ~flush. This ready chain is combinational; there is no registered path from out_ready to in_ready.
- Slot update when adv[i]=1: the slot loads from its upstream neighbour (slot 0 loads from the input, using in_valid & in_ready as its valid).
  - If the loaded valid is 0, ctrl is loaded as 0 and data holds its old value.
- Slot update when adv[i]=0: valid, ctrl and data all hold (stall).
- Bubble handling: a valid[i] that falls to 0 leaves an empty slot, which is collapsed by the advance rule. Beats are never duplicated or lost unless flush is asserted.
- Flush:
  - Next cycle, every valid=0 and every ctrl=0; data holds.
  - The input beat in the flush cycle is not accepted.
  - The out_valid/out_ready handshake in the flush cycle still counts as delivered downstream, because the outputs are combinational from state.
- Latency and throughput: STAGES cycles from acceptance to out_valid when no stall occurs; full throughput of 1 beat per cycle.
- Full condition: with all slots valid and out_ready=0, in_ready=0 and all state holds.
- Full plus simultaneous events: if out_ready=1 and in_valid=1 in the same cycle, accept and deliver at once; occupancy is unchanged.
- occupancy: registered.
  - +1 on an accepted input without output transfer.
  - -1 on an output transfer without accepted input.
  - 0 after flush or reset.
  - Never exceeds STAGES and never wraps.
- Output invariant: out_ctrl==0 whenever out_valid==0.
- Reset mid-stall or mid-flush: reset wins, giving the reset state on the next cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - per-boundary CTRL_W/DATA_W constants (EX_MEM_CTRL_W=7, EX_MEM_DATA_W=51, ...);
  - CTRL bit-index constants, so stages agree on the layout of the control field.
- One sub-module, pipe_slot: a single slot with valid, ctrl and data registers. It has inputs load, in_valid, in_ctrl, in_data and flush, and implements the zero-ctrl-on-bubble rule.
- pipe_stage_elastic instantiates STAGES copies of pipe_slot via generate, plus the ready chain and the occupancy counter.

Test Plan:
- Reset and stream, STAGES=1:
  - Stimulus: assert rst for 2 cycles, then in_valid=1 with ctrl=0x05, data=0x1234 and out_ready=1.
  - Response: all outputs 0 during reset; next cycle out_valid=1, out_ctrl=0x05, out_data=0x1234, occupancy=1.
- Backpressure, STAGES=2:
  - Stimulus: out_ready=0; offer beats A=0x0001 and B=0x0002, then C=0x0003 held valid.
  - Response: A and B accepted; in_ready=0 while C waits; occupancy=2.
  - Release: set out_ready=1.
  - Response: A, B, C delivered in order on consecutive cycles; no duplicates.
- Bubble collapse, STAGES=3:
  - Stimulus: in_valid pattern 1,0,1 with out_ready=0.
  - Response: both beats sit in slots 2 and 1 (slot 2 is the last slot); occupancy=2; in_ready=1; the empty slot has ctrl=0.
- Flush with simultaneous input, STAGES=2, full:
  - Stimulus: flush=1 together with in_valid=1, data=0xBEEF.
  - Response: next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xBEEF is never emitted.
- Full-pipe simultaneous in/out, STAGES=4:
  - Stimulus: pipe full, in_valid=1, out_ready=1 for 10 cycles.
  - Response: 10 beats out in order; occupancy stays 4; in_ready=1 throughout.
- Reset during stall:
  - Stimulus: occupancy=3, out_ready=0, then rst=1.
  - Response: next cycle occupancy=0, out_valid=0, out_data=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: control/payload widths per stage
// boundary and the agreed bit layout of the control field.
package pipe_pkg;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 32;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 48;
  localparam int EX_MEM_CTRL_W = 7;
  localparam int EX_MEM_DATA_W = 51;
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 35;

  // Control-field bit positions; later boundaries keep a prefix of this layout.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_HALT     = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_REGDST   = 7;

  typedef enum logic [1:0] {
    BND_IF_ID  = 2'd0,
    BND_ID_EX  = 2'd1,
    BND_EX_MEM = 2'd2,
    BND_MEM_WB = 2'd3
  } boundary_e;

  function automatic int ctrl_w_of(input boundary_e b);
    case (b)
      BND_IF_ID:  return IF_ID_CTRL_W;
      BND_ID_EX:  return ID_EX_CTRL_W;
      BND_EX_MEM: return EX_MEM_CTRL_W;
      BND_MEM_WB: return MEM_WB_CTRL_W;
      default:    return ID_EX_CTRL_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the elastic pipe: valid, control and payload.
// Control is zeroed whenever the slot goes empty; payload only resets.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = in_valid;
      // A bubble carries no control; its payload is left untouched.
      ctrl_d  = in_valid ? in_ctrl : '0;
      data_d  = in_valid ? in_data : data_q;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: STAGES slots in series with a
// combinational ready chain, synchronous flush and registered occupancy.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int STAGES = 1,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] adv_s;
  logic [CTRL_W-1:0] ctrl_s [STAGES];
  logic [DATA_W-1:0] data_s [STAGES];
  logic              accept_s;
  logic              deliver_s;
  logic [CNT_W-1:0]  occ_q, occ_d;

  // A slot may advance if it is empty or everything downstream moves.
  always_comb begin
    adv_s = '0;
    adv_s[STAGES-1] = out_ready | ~valid_s[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv_s[i] = adv_s[i+1] | ~valid_s[i];
    end
  end

  assign in_ready  = adv_s[0] & ~flush;
  assign accept_s  = in_valid & in_ready;
  assign deliver_s = out_valid & out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic              up_valid_s;
    logic [CTRL_W-1:0] up_ctrl_s;
    logic [DATA_W-1:0] up_data_s;

    if (i == 0) begin : g_head
      assign up_valid_s = accept_s;
      assign up_ctrl_s  = in_ctrl;
      assign up_data_s  = in_data;
    end else begin : g_body
      assign up_valid_s = valid_s[i-1];
      assign up_ctrl_s  = ctrl_s[i-1];
      assign up_data_s  = data_s[i-1];
    end

    pipe_slot #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (adv_s[i]),
      .in_valid(up_valid_s),
      .in_ctrl (up_ctrl_s),
      .in_data (up_data_s),
      .valid   (valid_s[i]),
      .ctrl    (ctrl_s[i]),
      .data    (data_s[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept_s && !deliver_s) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (deliver_s && !accept_s) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = valid_s[STAGES-1];
  assign out_ctrl  = ctrl_s[STAGES-1];
  assign out_data  = data_s[STAGES-1];
  assign occupancy = occ_q;

endmodule
